// File: rtl/bbc_bus_pkg.sv
// Shared constants for the BBC motherboard bus sequencer: register addresses
// of the write-only mapping registers and the access-sequencer state encoding.
package bbc_bus_pkg;

   localparam logic [15:0] PAGED_ROM_SEL_ADR  = 16'hFE30;
   localparam logic [15:0] SHADOW_RAM_SEL_ADR = 16'hFE34;
   localparam int          SHADOW_SEL_BIT     = 7;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARM  = 3'd1,
      PH1  = 3'd2,
      PH2  = 3'd3,
      DONE = 3'd4
   } bbc_state_e;

endpackage

// File: rtl/bbc_phi0_sync.sv
// Brings the asynchronous BBC phi0 clock into the hsclk domain and produces
// registered one-cycle fall/rise pulses (latency SYNC_STAGES+1 hsclk cycles).
module bbc_phi0_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic hsclk,
   input  logic resetb,
   input  logic phi0_i,
   output logic fall_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q;
   logic                   fall_q;
   logic                   rise_q;

   generate
      if (SYNC_STAGES < 2) begin : g_bad_stages
         $error("bbc_phi0_sync: SYNC_STAGES must be at least 2");
      end
   endgenerate

   // Synchroniser chain plus edge detection against the previous synchronised value
   always_ff @(posedge hsclk or negedge resetb) begin
      if (!resetb) begin
         sync_q <= '0;
         last_q <= 1'b0;
         fall_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], phi0_i};
         last_q <= sync_q[SYNC_STAGES-1];
         fall_q <= last_q & ~sync_q[SYNC_STAGES-1];
         rise_q <= ~last_q & sync_q[SYNC_STAGES-1];
      end
   end

   assign fall_o = fall_q;
   assign rise_o = rise_q;

endmodule

// File: rtl/bbc_cycle_ctrl.sv
// Runs one CPU access out onto the BBC bus, aligned to phi0, and mirrors the
// &FE30 / &FE34 mapping registers. Optional per-edge timeout: BBC_CYCLE_TIMEOUT_EN.
module bbc_cycle_ctrl
   import bbc_bus_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TMO_W          = 8
) (
   input  logic        hsclk,
   input  logic        resetb,
   input  logic        cpu_req,
   input  logic        cpu_rnw,
   input  logic [15:0] cpu_adr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_rdy,
   output logic        cpu_err,
   output logic        busy,
   input  logic        bbc_phi0,
   output logic        lat_en,
   output logic        bbc_rnw,
   output logic        bbc_data_oe,
   output logic [7:0]  rom_sel,
   output logic        shadow_sel
);

   generate
      if (TMO_W < 1 || TMO_W > 30 || (1 << TMO_W) <= TIMEOUT_CYCLES) begin : g_bad_tmo
         $error("bbc_cycle_ctrl: TMO_W too narrow for TIMEOUT_CYCLES");
      end
   endgenerate

   logic       phi0_fall_s;
   logic       phi0_rise_s;

   bbc_state_e state_q, state_d;
   logic       rnw_q, rnw_d;
   logic [7:0] wdata_q, wdata_d;
   logic       is_rom_q, is_rom_d;
   logic       is_shd_q, is_shd_d;
   logic       lat_en_q, lat_en_d;
   logic       bbc_rnw_q, bbc_rnw_d;
   logic       data_oe_q, data_oe_d;
   logic       rdy_q, rdy_d;
   logic       busy_q, busy_d;
   logic [7:0] rom_sel_q, rom_sel_d;
   logic       shadow_sel_q, shadow_sel_d;
   logic       tmo_hit_s;
   logic       tmo_exit_s;

`ifdef BBC_CYCLE_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
   logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc_s;
   logic             err_q, err_d;
`endif

   bbc_phi0_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_phi0_sync (
      .hsclk (hsclk),
      .resetb(resetb),
      .phi0_i(bbc_phi0),
      .fall_o(phi0_fall_s),
      .rise_o(phi0_rise_s)
   );

   // Next-state and registered-output logic; outputs change only on state entry
   always_comb begin
      state_d      = state_q;
      rnw_d        = rnw_q;
      wdata_d      = wdata_q;
      is_rom_d     = is_rom_q;
      is_shd_d     = is_shd_q;
      lat_en_d     = lat_en_q;
      bbc_rnw_d    = bbc_rnw_q;
      data_oe_d    = data_oe_q;
      rdy_d        = 1'b0;
      rom_sel_d    = rom_sel_q;
      shadow_sel_d = shadow_sel_q;
      tmo_exit_s   = 1'b0;
`ifdef BBC_CYCLE_TIMEOUT_EN
      tmo_inc_s    = tmo_q + TMO_W'(1);
      tmo_hit_s    = (tmo_inc_s == TMO_LIMIT);
`else
      tmo_hit_s    = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               rnw_d    = cpu_rnw;
               wdata_d  = cpu_wdata;
               is_rom_d = (cpu_adr == PAGED_ROM_SEL_ADR);
               is_shd_d = (cpu_adr == SHADOW_RAM_SEL_ADR);
               state_d  = ARM;
            end else begin
               state_d  = IDLE;
            end
         end
         ARM: begin
            if (phi0_fall_s) begin
               state_d = PH1;
            end else if (tmo_hit_s) begin
               state_d    = DONE;
               tmo_exit_s = 1'b1;
            end else begin
               state_d = ARM;
            end
         end
         PH1: begin
            if (phi0_rise_s) begin
               state_d = PH2;
            end else if (tmo_hit_s) begin
               state_d    = DONE;
               tmo_exit_s = 1'b1;
            end else begin
               state_d = PH1;
            end
         end
         PH2: begin
            if (phi0_fall_s) begin
               state_d = DONE;
            end else if (tmo_hit_s) begin
               state_d    = DONE;
               tmo_exit_s = 1'b1;
            end else begin
               state_d = PH2;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A timed-out access completes without touching the mapping registers
      if (state_d != state_q) begin
         case (state_d)
            IDLE: lat_en_d = 1'b1;
            ARM:  lat_en_d = 1'b1;
            PH1: begin
               lat_en_d  = 1'b0;
               bbc_rnw_d = rnw_q;
            end
            PH2:  data_oe_d = ~rnw_q;
            DONE: begin
               rdy_d     = 1'b1;
               data_oe_d = 1'b0;
               bbc_rnw_d = 1'b1;
               if (!rnw_q && !tmo_exit_s) begin
                  if (is_rom_q) begin
                     rom_sel_d = wdata_q;
                  end else begin
                     rom_sel_d = rom_sel_q;
                  end
                  if (is_shd_q) begin
                     shadow_sel_d = wdata_q[SHADOW_SEL_BIT];
                  end else begin
                     shadow_sel_d = shadow_sel_q;
                  end
               end else begin
                  rom_sel_d = rom_sel_q;
               end
            end
            default: lat_en_d = 1'b1;
         endcase
      end else begin
         lat_en_d = lat_en_q;
      end

      busy_d = (state_d != IDLE);

`ifdef BBC_CYCLE_TIMEOUT_EN
      err_d = tmo_exit_s;
      if (state_d != state_q) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_inc_s;
      end
`endif
   end

   // State, capture and output registers
   always_ff @(posedge hsclk or negedge resetb) begin
      if (!resetb) begin
         state_q      <= IDLE;
         rnw_q        <= 1'b1;
         wdata_q      <= 8'h00;
         is_rom_q     <= 1'b0;
         is_shd_q     <= 1'b0;
         lat_en_q     <= 1'b1;
         bbc_rnw_q    <= 1'b1;
         data_oe_q    <= 1'b0;
         rdy_q        <= 1'b0;
         busy_q       <= 1'b0;
         rom_sel_q    <= 8'h00;
         shadow_sel_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rnw_q        <= rnw_d;
         wdata_q      <= wdata_d;
         is_rom_q     <= is_rom_d;
         is_shd_q     <= is_shd_d;
         lat_en_q     <= lat_en_d;
         bbc_rnw_q    <= bbc_rnw_d;
         data_oe_q    <= data_oe_d;
         rdy_q        <= rdy_d;
         busy_q       <= busy_d;
         rom_sel_q    <= rom_sel_d;
         shadow_sel_q <= shadow_sel_d;
      end
   end

`ifdef BBC_CYCLE_TIMEOUT_EN
   // Per-edge wait counter and error flag
   always_ff @(posedge hsclk or negedge resetb) begin
      if (!resetb) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end

   assign cpu_err = err_q;
`else
   assign cpu_err = 1'b0;
`endif

   assign cpu_rdy     = rdy_q;
   assign busy        = busy_q;
   assign lat_en      = lat_en_q;
   assign bbc_rnw     = bbc_rnw_q;
   assign bbc_data_oe = data_oe_q;
   assign rom_sel     = rom_sel_q;
   assign shadow_sel  = shadow_sel_q;

endmodule
